// File: rtl/pulse_channel_arbiter.sv
// pulse_channel_arbiter
//   Shares one stretched pulse output between N event requesters. Single-cycle
//   strobes are latched as pending and served round-robin; each grant holds
//   pulse_o high for ON_CYCLES, then low for GAP_CYCLES, so every event shows
//   up as its own distinct pulse.
//
// Ports
//   clk        clock
//   reset      asynchronous, active-high reset
//   req_i      [N] event strobes, one event per high cycle
//   enable_i   low blocks new grants (events still latch)
//   pulse_o    shared stretched output
//   grant_o    [N] one-hot owner of the current ON phase, else zero
//   pending_o  [N] latched events not yet served
//   dropped_o  [N] 1-cycle strobe: event merged into an already-pending bit
//   busy_o     high while in ON or GAP
module pulse_channel_arbiter #(
  parameter int N          = 4,
  parameter int ON_CYCLES  = 100,
  parameter int GAP_CYCLES = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         enable_i,
  output logic         pulse_o,
  output logic [N-1:0] grant_o,
  output logic [N-1:0] pending_o,
  output logic [N-1:0] dropped_o,
  output logic         busy_o
);

  localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  dropped_q, dropped_d;

  logic [N-1:0]  eff;
  logic [PW-1:0] win_idx;
  logic          win_found;
  int            idx;

  // Round-robin search starting just after the last winner. A strobe arriving
  // this cycle is visible here, so it can win immediately.
  always_comb begin
    eff       = pending_q | req_i;
    win_idx   = ptr_q;
    win_found = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!win_found && eff[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  logic on_done, gap_done, arb_pt, go;

  // Counters compare before incrementing, so they never exceed the phase length.
  assign on_done  = (state_q == S_ON)  && (cnt_q == ON_LAST);
  assign gap_done = (state_q == S_GAP) && (cnt_q == GAP_LAST);
  // With no gap, the end of ON is itself an arbitration point (back-to-back ON).
  assign arb_pt   = (state_q == S_IDLE) || gap_done || (on_done && (GAP_CYCLES == 0));
  assign go       = arb_pt && enable_i && win_found;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    pending_d = pending_q | req_i;
    dropped_d = req_i & pending_q;

    case (state_q)
      S_ON: begin
        if (on_done) begin
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          cnt_d   = '0;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_done) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A new grant overrides the fall-through above; the winner's own strobe
    // this cycle is consumed by the grant rather than left pending.
    if (go) begin
      state_d            = S_ON;
      cnt_d              = '0;
      ptr_d              = win_idx;
      pending_d[win_idx] = 1'b0;
      for (int k = 0; k < N; k++) grant_d[k] = (PW'(k) == win_idx);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= PW'(N - 1);
      pending_q <= '0;
      grant_q   <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      dropped_q <= dropped_d;
    end
  end

  assign pulse_o   = (state_q == S_ON);
  assign busy_o    = (state_q != S_IDLE);
  assign grant_o   = grant_q;
  assign pending_o = pending_q;
  assign dropped_o = dropped_q;

endmodule

// File: doc/pulse_channel_arbiter.md
# pulse_channel_arbiter

Shares one stretched indicator/pulse channel between N event requesters. Each requester raises single-cycle event strobes; the arbiter latches them as pending and grants the channel round-robin. Each grant drives the shared output high for a fixed on-time, then low for a fixed gap, so every event is visible as a distinct pulse. It sits between event sources (error, link, activity strobes) and a single physical output such as an LED or debug pin.

## Interface
- N, 4: number of requesters, ≥1.
- ON_CYCLES, 100: cycles pulse_o is high per grant, ≥1.
- GAP_CYCLES, 20: cycles pulse_o is forced low after each grant, ≥0.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_i  in  N  event strobes; each high cycle is one event.
- enable_i  in  1  when low, no new grant starts; events still latch.
- pulse_o  out  1  shared stretched output.
- grant_o  out  N  one-hot owner of the current ON phase; zero otherwise.
- pending_o  out  N  latched, not-yet-served events.
- dropped_o  out  N  1-cycle strobe: event coalesced into an already-pending bit.
- busy_o  out  1  high in ON or GAP.

## Operation
- Reset values: pulse_o=0, grant_o=0, pending_o=0, dropped_o=0, busy_o=0, state IDLE, counter 0, RR pointer=N-1 so index 0 has first priority.
- Effective request eff = pending_o | req_i. Arbitration uses eff, so a strobe can win in the cycle it arrives.
- Round-robin: search eff from (pointer+1) mod N upward with wrap. The winner becomes the pointer.
- States:
  - IDLE: if enable_i and eff≠0, go to ON. In the same edge, set grant_o=onehot(winner), set pulse_o=1, load counter=0, and clear the winner's pending bit. The winner's pending bit is also not set by the same-cycle strobe.
  - ON: counter increments each cycle. When counter==ON_CYCLES-1:
    - if GAP_CYCLES>0, go to GAP, pulse_o=0, grant_o=0, counter=0;
    - if GAP_CYCLES==0, arbitrate as in IDLE: re-grant directly (pulse_o stays 1) or go to IDLE.
  - GAP: counter increments. When counter==GAP_CYCLES-1, arbitrate as in IDLE: go to ON (back-to-back) or to IDLE.
- Pending update per bit, unless it is the grant winner that edge: pending <= pending | req_i.
- dropped_o[k] is high for 1 cycle when req_i[k]=1 and pending_o[k] is already 1. The event merges.
- A strobe from the current owner during ON/GAP sets its pending bit and is served in a later grant. It never extends the current pulse.
- enable_i low: the current ON/GAP runs to completion, then the block holds in IDLE while pending accumulates.
- Counter width: clog2(max(ON_CYCLES, GAP_CYCLES)+1) bits. The counter never wraps, because it compares for equality before increment.

## Timing
- Latency: a strobe at cycle t in IDLE with enable_i=1 gives pulse_o/grant_o high from cycle t+1.
- pulse_o high for exactly ON_CYCLES cycles per grant. The grant period is ON_CYCLES+GAP_CYCLES with no idle cycle between back-to-back grants.
- All outputs are registered, with no combinational input-to-output path.
- Reset asserted mid-operation clears all state and outputs immediately. Pending events are discarded.
- Fairness: with all N requesting continuously, each requester is granted exactly once per N grants.

## Test plan
Bench config N=4, ON=4, GAP=2.
- Single event: req_i=0001 at cycle 0 → pulse_o and grant_o=0001 in cycles 1–4; pulse_o=0, busy_o=1 in cycles 5–6; busy_o=0 from cycle 7; pending_o stays 0.
- Simultaneous events: req_i=1011 at cycle 0 → grants 0001 (cycles 1–4), 0010 (7–10), 1000 (13–16); pending_o=1010 at cycle 1, 1000 at cycle 7, 0000 at cycle 13.
- Coalescing: req_i[2] at cycles 0 and 3 while req_i[0] is granted at cycle 1 → dropped_o=0100 at cycle 4 only; exactly one grant of 0100 (cycles 7–10).
- Fairness: req_i=1001 held continuously → grant sequence 0001, 1000, 0001, 1000, each 4 cycles on, 2 cycles gap.
- Reset mid-ON: reset at cycle 2 of a grant with pending_o=0110 → all outputs 0 immediately. After release with no req, the block stays idle.
- Enable gating: enable_i=0 and req_i=0100 at cycle 0 → pending_o=0100, pulse_o=0. enable_i=1 at cycle 5 → grant_o=0100, pulse_o=1 at cycle 6.
